serializer: RTL and testbench
=============================

// Module: serializer
//
// PURPOSE
//   Splits one wide dti word into up to LANES narrow beats. It emits one beat per
//   accepted dout handshake, lane 0 (LSBs) first.
//   Sits directly downstream of a decoupler in width-conversion paths, draining
//   its wide output onto a narrow dti channel.
//   The last beat of each word is flagged.
//   There is no bubble between consecutive words.
//
// PARAMETERS
//   LANES   4  number of lanes per input word; must be >= 2
//   W_LANE  8  width of one lane in bits
//   (derived) W_CNT = $clog2(LANES); W_DIN = W_CNT + LANES*W_LANE; W_DOUT = W_LANE + 1
//
// PORTS
//   clk   in   1       clock; all state is updated on its rising edge
//   rst   in   1       reset; asynchronous, active-high
//   din   dti.consumer W_DIN   data = {cnt[W_CNT-1:0], lanes[LANES*W_LANE-1:0]}
//                              cnt = number of used lanes minus 1
//   dout  dti.producer W_DOUT  data = {last, lane[W_LANE-1:0]}
//
// BEHAVIOUR
// - State: busy flag, lane index idx[W_CNT-1:0], holding register {cnt_q, lanes_q}.
// - Reset (rst=1, async): busy=0, idx=0, holding register '0.
//     dout.valid=0 immediately. din.ready=1 (idle).
//     Inputs are ignored while rst=1.
// - IDLE (busy=0):
//     dout.valid=0; din.ready=1.
//     On din.valid: capture the word, set idx=0, go to SER.
//     Latency: first beat is valid 1 cycle after the din handshake.
// - SER (busy=1):
//     dout.valid=1.
//     dout.data = {idx==cnt_q, lanes_q[idx*W_LANE +: W_LANE]}.
//   - dout.ready & idx<cnt_q: idx <= idx+1.
//   - dout.ready & idx==cnt_q & din.valid: capture the new word, idx <= 0, stay in SER.
//     This gives back-to-back words with no bubble.
//   - dout.ready & idx==cnt_q & ~din.valid: busy <= 0.
//   - ~dout.ready: all state held. dout.data stays stable while valid (dti rule).
// - din.ready = ~busy | (dout.ready & idx==cnt_q).
//     This is combinational from dout.ready. There is no path from din.valid to din.ready.
// - cnt > LANES-1 (LANES not a power of 2): clamp to LANES-1 at capture.
//     Unused lanes are never emitted.
// - Throughput: cnt+1 cycles per word at full dout.ready. Peak rate is 1 beat/cycle.
// - Reset mid-word: the remaining beats are discarded.
//     After rst deasserts, the next accepted word starts at lane 0.
// - Elaboration checks: $error if $size(din.data) != W_DIN, if $size(dout.data) != W_DOUT,
//   or if LANES < 2.
//
// STRUCTURE
// - Shared package dti_pkg:
//     function lane_cnt_w(lanes) returning $clog2(lanes).
//     Parameterised packed struct for the din payload {cnt, lanes}, reused by a future deserializer.
// - Single module with no sub-module.
//   The upstream decoupler is instanced by the parent, not inside this block.
//
// TESTING (LANES=4, W_LANE=8)
// 1. Reset: assert rst mid-cycle during SER.
//    -> dout.valid=0 in the same cycle; after release din.ready=1 and dout.valid=0.
// 2. Single word cnt=3, lanes=32'h44332211, dout.ready=1.
//    -> dout 0x011, 0x022, 0x033, 0x144 on cycles 1..4; din.ready=0 on cycles 1..3.
// 3. Words A(cnt=0, 0xAA) and B(cnt=0, 0xBB) back-to-back.
//    -> dout 0x1AA then 0x1BB on consecutive cycles; din.ready stays 1.
// 4. cnt=2, lanes=32'hxx_CC_BB_AA, dout.ready pattern 1,0,1,0,1.
//    -> beats 0x0AA, 0x0BB, 0x1CC; data held while ready=0; nothing dropped or duplicated.
// 5. cnt=3; rst pulses after 2 beats; then send cnt=1, lanes=16'h5566.
//    -> no stale beats; dout 0x066, 0x155.
// 6. 10k words with random cnt, din.valid and dout.ready, checked against a scoreboard.
//    -> beat count = sum(cnt+1); order matches; last asserted exactly once per word.

Source files
------------

// File: rtl/dti_pkg.sv
// Shared definitions for dti width-conversion blocks (serializer, future deserializer).
package dti_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SER  = 1'b1
  } ser_state_e;

  // Width of the lane-count field that accompanies a wide dti word.
  function automatic int unsigned lane_cnt_w(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/serializer_if.sv
// dti valid/ready channel; the producer drives valid/data, the consumer drives ready.
interface dti #(
  parameter int unsigned W = 8
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
  modport master   (output valid, output data, input  ready);
  modport slave    (input  valid, input  data, output ready);

endinterface

// File: rtl/serializer.sv
// Splits one wide dti word into up to LANES narrow beats, lane 0 first, flagging
// the last beat; consecutive words stream without a bubble.
module serializer
  import dti_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned W_LANE = 8
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din,
  dti.producer dout
);

  localparam int unsigned W_CNT  = lane_cnt_w(LANES);
  localparam int unsigned W_DIN  = W_CNT + LANES * W_LANE;
  localparam int unsigned W_DOUT = W_LANE + 1;

  if (LANES < 2) begin : g_chk_lanes
    $error("serializer: LANES must be >= 2");
  end
  if ($bits(din.data) != W_DIN) begin : g_chk_din
    $error("serializer: din.data width does not match W_DIN");
  end
  if ($bits(dout.data) != W_DOUT) begin : g_chk_dout
    $error("serializer: dout.data width does not match W_DOUT");
  end

  typedef struct packed {
    logic [W_CNT-1:0]              cnt;
    logic [LANES-1:0][W_LANE-1:0]  lanes;
  } din_word_t;

  din_word_t        din_word;
  logic [W_CNT-1:0] cnt_in;

  assign din_word = din.data;

  // Counts beyond the last real lane only exist when LANES is not a power of two.
  if (LANES == (1 << W_CNT)) begin : g_no_clamp
    assign cnt_in = din_word.cnt;
  end else begin : g_clamp
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(LANES - 1);
    assign cnt_in = (din_word.cnt > CNT_MAX) ? CNT_MAX : din_word.cnt;
  end

  ser_state_e                    state_q, state_d;
  logic [W_CNT-1:0]              idx_q, idx_d;
  logic [W_CNT-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][W_LANE-1:0]  lanes_q, lanes_d;
  logic                          last_c;
  logic                          din_ready_c;

  assign last_c      = (idx_q == cnt_q);
  assign din_ready_c = (state_q == ST_IDLE) | (dout.ready & last_c);

  assign din.ready  = din_ready_c;
  assign dout.valid = (state_q == ST_SER);
  assign dout.data  = {last_c, lanes_q[idx_q]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  // Next-state: advance the lane index, reload on the last beat, or drop to idle.
  always_comb begin
    logic load;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (din.valid) load = 1'b1;
      end
      ST_SER: begin
        if (dout.ready) begin
          if (!last_c) begin
            idx_d = idx_q + W_CNT'(1);
          end else if (din.valid) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_SER;
      idx_d   = '0;
      cnt_d   = cnt_in;
      lanes_d = din_word.lanes;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed and scoreboard checks of the serializer with LANES=4, W_LANE=8.
module tb_serializer;

  localparam int unsigned LANES  = 4;
  localparam int unsigned W_LANE = 8;
  localparam int unsigned W_DIN  = 2 + LANES * W_LANE;
  localparam int unsigned W_DOUT = W_LANE + 1;
  localparam int unsigned N_WORDS = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  dti #(.W(W_DIN))  din_if ();
  dti #(.W(W_DOUT)) dout_if ();

  serializer #(.LANES(LANES), .W_LANE(W_LANE)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if.consumer),
    .dout (dout_if.producer)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [W_DIN-1:0] d, input logic r);
    @(negedge clk);
    din_if.valid  = v;
    din_if.data   = d;
    dout_if.ready = r;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_if.valid);
    else n_pass++;
    n_chk++;
    if (din_if.ready !== 1'b1) $display("FAIL reset_din_ready got %b want 1", din_if.ready);
    else n_pass++;
    rst = 1'b0;
    drive(1'b1, {2'd3, 32'h44332211}, 1'b0);
    drive(1'b0, '0, 1'b0);
    n_chk++;
    if (dout_if.valid !== 1'b1) $display("FAIL reset_pre_ser got %b want 1", dout_if.valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL reset_async_valid got %b want 0", dout_if.valid);
    else n_pass++;
    drive(1'b1, {2'd3, 32'h99999999}, 1'b1);
    rst = 1'b0;
    din_if.valid = 1'b0;
    #1;
    n_chk++;
    if (din_if.ready !== 1'b1 || dout_if.valid !== 1'b0)
      $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0",
               din_if.ready, dout_if.valid);
    else n_pass++;
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL reset_stays_idle got %b want 0", dout_if.valid);
    else n_pass++;
  endtask

  task automatic test_single_word();
    logic [8:0] exp_b [4] = '{9'h011, 9'h022, 9'h033, 9'h144};
    logic       exp_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, {2'd3, 32'h44332211}, 1'b1);
    n_chk++;
    if (din_if.ready !== 1'b1) $display("FAIL single_accept got %b want 1", din_if.ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      n_chk++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_b[i] || din_if.ready !== exp_r[i])
        $display("FAIL single_beat%0d got v=%b d=%h r=%b want v=1 d=%h r=%b", i,
                 dout_if.valid, dout_if.data, din_if.ready, exp_b[i], exp_r[i]);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL single_idle got %b want 0", dout_if.valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, {2'd0, 32'h000000AA}, 1'b1);
    drive(1'b1, {2'd0, 32'h000000BB}, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b1 || dout_if.data !== 9'h1AA || din_if.ready !== 1'b1)
      $display("FAIL b2b_a got v=%b d=%h r=%b want v=1 d=1aa r=1",
               dout_if.valid, dout_if.data, din_if.ready);
    else n_pass++;
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b1 || dout_if.data !== 9'h1BB || din_if.ready !== 1'b1)
      $display("FAIL b2b_b got v=%b d=%h r=%b want v=1 d=1bb r=1",
               dout_if.valid, dout_if.data, din_if.ready);
    else n_pass++;
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", dout_if.valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic       rdy   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] exp_b [5] = '{9'h0AA, 9'h0BB, 9'h0BB, 9'h1CC, 9'h1CC};
    drive(1'b1, {2'd2, 32'h55CCBBAA}, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, rdy[i]);
      n_chk++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_b[i])
        $display("FAIL bp_cycle%0d got v=%b d=%h want v=1 d=%h", i,
                 dout_if.valid, dout_if.data, exp_b[i]);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL bp_idle got %b want 0", dout_if.valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    logic [8:0] exp_b [2] = '{9'h066, 9'h155};
    drive(1'b1, {2'd3, 32'h44332211}, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.data !== 9'h022) $display("FAIL midrst_pre got %h want 022", dout_if.data);
    else n_pass++;
    rst = 1'b1;
    drive(1'b0, '0, 1'b1);
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL midrst_flushed got %b want 0", dout_if.valid);
    else n_pass++;
    drive(1'b1, {2'd1, 32'h00005566}, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1);
      n_chk++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_b[i])
        $display("FAIL midrst_beat%0d got v=%b d=%h want v=1 d=%h", i,
                 dout_if.valid, dout_if.data, exp_b[i]);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (dout_if.valid !== 1'b0) $display("FAIL midrst_idle got %b want 0", dout_if.valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    int sent      = 0;
    int exp_beats = 0;
    int got_beats = 0;
    int got_last  = 0;
    int drain     = 0;
    logic [1:0]  cnt;
    logic [31:0] lanes;
    logic [8:0]  e;
    while (sent < int'(N_WORDS) || exp_q.size() != 0 || dout_if.valid === 1'b1) begin
      if (sent >= int'(N_WORDS)) begin
        drain++;
        if (drain > 200) break;
      end
      cnt   = 2'($urandom_range(0, 3));
      lanes = $urandom;
      drive((sent < int'(N_WORDS)) && ($urandom_range(0, 3) != 0), {cnt, lanes},
            (sent >= int'(N_WORDS)) || ($urandom_range(0, 3) != 0));
      if (dout_if.valid === 1'b1 && dout_if.ready === 1'b1) begin
        got_beats++;
        if (dout_if.data[8] === 1'b1) got_last++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1xx;
        n_chk++;
        if (dout_if.data !== e)
          $display("FAIL rand_beat%0d got %h want %h", got_beats, dout_if.data, e);
        else n_pass++;
      end
      if (din_if.valid === 1'b1 && din_if.ready === 1'b1) begin
        for (int i = 0; i <= int'(cnt); i++)
          exp_q.push_back({(i == int'(cnt)), lanes[i*8 +: 8]});
        exp_beats += int'(cnt) + 1;
        sent++;
      end
    end
    n_chk++;
    if (drain > 200 || exp_q.size() != 0)
      $display("FAIL rand_drain got %0d pending want 0", exp_q.size());
    else n_pass++;
    n_chk++;
    if (got_beats != exp_beats)
      $display("FAIL rand_beat_count got %0d want %0d", got_beats, exp_beats);
    else n_pass++;
    n_chk++;
    if (got_last != sent || sent != int'(N_WORDS))
      $display("FAIL rand_last_count got %0d want %0d", got_last, N_WORDS);
    else n_pass++;
  endtask

  initial begin
    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
